// File: rtl/dfpbm_pkg.sv
// Shared types and constants for the DFP bus master: FSM state encoding,
// counter width and the value returned by a read that timed out.
package dfpbm_pkg;

   localparam int          CNT_W      = 10;
   localparam logic [15:0] RD_TIMEOUT = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      HALT_REQ,
      SETUP,
      STROBE,
      WAIT,
      HOLD,
      RELEASE,
      HALTED_IDLE
   } state_e;

   // Converts a cycle count into a counter load value, clamped to the counter range.
   function automatic logic [CNT_W-1:0] cnt_of(input int n);
      if (n <= 0)
         return '0;
      else if (n >= (1 << CNT_W))
         return '1;
      else
         return CNT_W'(n);
   endfunction

endpackage

// File: rtl/dfpbm_timer.sv
// Loadable down-counter, saturating at zero, with an expire flag.
// One instance is shared by every timed state of the DFP bus master.
module dfpbm_timer
   import dfpbm_pkg::*;
(
   input  logic             clk1,
   input  logic             nreset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk1 or negedge nreset) begin
      if (!nreset)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/dfp_bus_master.sv
// Front-panel bus master: halts the CPU, runs one memory/I-O bus cycle, responds.
// Optional DFPBM_HOLD_EN keeps the halt between closely spaced requests.
module dfp_bus_master
   import dfpbm_pkg::*;
#(
   parameter int SETUP_CYC    = 1,
   parameter int STROBE_CYC   = 2,
   parameter int WS_TIMEOUT   = 255,
   parameter int HALT_TIMEOUT = 1023,
   parameter int HOLD_CYC     = 8
) (
   input  logic        clk1,
   input  logic        nreset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_io,
   input  logic [23:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_timeout,
   input  logic        halted,
   output logic        nhalt_oe,
   input  logic        nws,
   output logic        bus_oe,
   output logic [23:0] ab_o,
   output logic        db_oe,
   output logic [15:0] db_o,
   input  logic [15:0] db_i,
   output logic        nmem_o,
   output logic        nio_o,
   output logic        nr_o,
   output logic        nw_o
);

   state_e           r_state;
   state_e           w_next;
   logic             w_accept;
   logic             w_expired;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_halt_tmo;
   logic             w_ws_tmo;
   logic             w_hold_entry;
   logic             w_rel_entry;

   logic [23:0]      r_addr;
   logic [15:0]      r_wdata;
   logic             r_write;
   logic             r_io;
   logic             r_tmo;
   logic [15:0]      r_cap;
   logic [15:0]      r_rdata;

   assign w_accept     = req_valid && req_ready;
   assign w_halt_tmo   = (r_state == HALT_REQ) && !halted && w_expired;
   assign w_ws_tmo     = (r_state == WAIT) && !nws && w_expired;
   assign w_hold_entry = (w_next == HOLD) && (r_state != HOLD);
   assign w_rel_entry  = (w_next == RELEASE) && (r_state != RELEASE);

   always_ff @(posedge clk1 or negedge nreset) begin
      if (!nreset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_accept) w_next = HALT_REQ;
         HALT_REQ: begin
            if (halted)
               w_next = SETUP;
            else if (w_expired)
               w_next = RELEASE;
         end
         SETUP:    if (w_expired) w_next = STROBE;
         STROBE:   if (w_expired) w_next = nws ? HOLD : WAIT;
         WAIT:     if (nws || w_expired) w_next = HOLD;
         HOLD:     w_next = RELEASE;
`ifdef DFPBM_HOLD_EN
         RELEASE:  w_next = HALTED_IDLE;
         HALTED_IDLE: begin
            if (w_accept)
               w_next = SETUP;
            else if (w_expired)
               w_next = IDLE;
         end
`else
         RELEASE:  w_next = IDLE;
`endif
         default:  w_next = IDLE;
      endcase
   end

   // The shared timer is reloaded whenever the FSM enters a new state.
   assign w_load = (w_next != r_state);

   always_comb begin
      w_load_val = '0;
      case (w_next)
         HALT_REQ:    w_load_val = cnt_of(HALT_TIMEOUT);
         SETUP:       w_load_val = cnt_of(SETUP_CYC - 1);
         STROBE:      w_load_val = cnt_of(STROBE_CYC - 1);
         WAIT:        w_load_val = cnt_of(WS_TIMEOUT - 1);
         HALTED_IDLE: w_load_val = cnt_of(HOLD_CYC - 1);
         default:     w_load_val = '0;
      endcase
   end

   dfpbm_timer u_timer (
      .clk1       (clk1),
      .nreset     (nreset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expired  (w_expired)
   );

   always_ff @(posedge clk1 or negedge nreset) begin
      if (!nreset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
         r_io    <= 1'b0;
         r_tmo   <= 1'b0;
         r_cap   <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_write <= req_write;
            r_io    <= req_io;
            r_tmo   <= 1'b0;
            r_cap   <= '0;
         end
         if (w_halt_tmo || w_ws_tmo)
            r_tmo <= 1'b1;
         if (w_hold_entry && !r_write)
            r_cap <= w_ws_tmo ? RD_TIMEOUT : db_i;
         // A halt timeout skips HOLD, so its read result is produced here directly.
         if (w_rel_entry)
            r_rdata <= (r_state == HALT_REQ) ? (r_write ? 16'h0000 : RD_TIMEOUT) : r_cap;
      end
   end

   assign rsp_rdata = r_rdata;

   always_comb begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_timeout = 1'b0;
      nhalt_oe    = 1'b0;
      bus_oe      = 1'b0;
      db_oe       = 1'b0;
      ab_o        = '0;
      db_o        = '0;
      nmem_o      = 1'b1;
      nio_o       = 1'b1;
      nr_o        = 1'b1;
      nw_o        = 1'b1;
      case (r_state)
         IDLE:     req_ready = 1'b1;
         HALT_REQ: nhalt_oe  = 1'b1;
         SETUP, STROBE, WAIT, HOLD: begin
            nhalt_oe = 1'b1;
            bus_oe   = 1'b1;
            ab_o     = r_addr;
            db_oe    = r_write;
            db_o     = r_write ? r_wdata : 16'h0000;
            if (r_state == STROBE || r_state == WAIT) begin
               nmem_o = r_io;
               nio_o  = !r_io;
               nr_o   = r_write;
               nw_o   = !r_write;
            end
         end
         RELEASE: begin
            rsp_valid   = 1'b1;
            rsp_timeout = r_tmo;
`ifdef DFPBM_HOLD_EN
            nhalt_oe    = 1'b1;
`endif
         end
`ifdef DFPBM_HOLD_EN
         HALTED_IDLE: begin
            nhalt_oe  = 1'b1;
            req_ready = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule
